// File: rtl/divsqrt_normshift_pipe.sv
// divsqrt post-processing normalisation shifter: derives the normal/subnormal
// left-shift amount (plus early-termination term) and applies it over STAGES register stages.
module divsqrt_normshift_pipe #(
    parameter int NE             = 11,
    parameter int NF             = 52,
    parameter int NFS            = 23,
    parameter int DIVb           = 63,
    parameter int NORMSHIFTSZ    = 128,
    parameter int LOGNORMSHIFTSZ = 7,
    parameter int RK             = 4,
    parameter int ETW            = 4,
    parameter int STAGES         = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Flush,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DIVb:0]             DivQm,
    input  logic [NE+1:0]             DivQe,
    input  logic                      Fmt,
    input  logic [ETW-1:0]            EarlyTerm,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [NORMSHIFTSZ-1:0]    Shifted,
    output logic [LOGNORMSHIFTSZ-1:0] ShiftAmt,
    output logic                      ResSubnorm,
    output logic                      SubnormShiftPos,
    output logic                      ShiftSat
);
    localparam int W    = (LOGNORMSHIFTSZ + STAGES - 1) / STAGES;
    localparam int AW   = W * STAGES;
    localparam int TW   = LOGNORMSHIFTSZ + ETW + 1;
    localparam int PADZ = NORMSHIFTSZ - DIVb - 1 - NF;

    logic [NE+1:0]             w_nfsel;
    logic [NE+1:0]             w_subshift;
    logic                      w_ressub;
    logic                      w_subpos;
    logic                      w_sat;
    logic [LOGNORMSHIFTSZ-1:0] w_base;
    logic [LOGNORMSHIFTSZ-1:0] w_amt;
    logic [TW-1:0]             w_total;
    logic [NORMSHIFTSZ-1:0]    w_data;
    logic                      w_unused;

    always_comb begin
        w_nfsel    = Fmt ? (NE+2)'(NF) : (NE+2)'(NFS);
        w_ressub   = DivQe[NE+1] | (DivQe == '0);
        w_subshift = w_nfsel + DivQe;
        w_subpos   = ~w_subshift[NE+1];
        if (w_ressub)
            w_base = w_subpos ? w_subshift[LOGNORMSHIFTSZ-1:0] : '0;
        else
            w_base = w_nfsel[LOGNORMSHIFTSZ-1:0];
        w_total = TW'(w_base) + TW'(EarlyTerm) * TW'(RK);
        w_sat   = w_total > TW'(NORMSHIFTSZ - 1);
        w_amt   = w_sat ? LOGNORMSHIFTSZ'(NORMSHIFTSZ - 1) : w_total[LOGNORMSHIFTSZ-1:0];
        w_data  = '0;
        w_data[PADZ +: DIVb+1] = DivQm;
    end

    // Subnormal shifts never exceed NF, so the upper SubShift bits carry no shift information.
    assign w_unused = ^w_subshift[NE:LOGNORMSHIFTSZ];

    logic [STAGES:0]           r_v;
    logic [NORMSHIFTSZ-1:0]    r_data [0:STAGES];
    logic [LOGNORMSHIFTSZ-1:0] r_amt  [0:STAGES];
    logic [STAGES:0]           r_sub;
    logic [STAGES:0]           r_pos;
    logic [STAGES:0]           r_sat;
    logic [STAGES:0]           w_adv;
    logic [AW-1:0]             w_amtpad [1:STAGES];
    logic [AW-1:0]             w_chunk  [1:STAGES];
    logic [NORMSHIFTSZ-1:0]    w_sh     [1:STAGES];

    // A stage advances if it or any later stage is empty, or the consumer takes the output.
    always_comb begin
        for (int unsigned k = 0; k <= STAGES; k++) begin
            w_adv[k] = OutReady | ~&(r_v | (((STAGES+1)'(1) << k) - (STAGES+1)'(1)));
        end
    end

    assign InReady = w_adv[0];

    always_comb begin
        for (int unsigned k = 1; k <= STAGES; k++) begin
            w_amtpad[k] = AW'(r_amt[k-1]);
            w_chunk[k]  = AW'(w_amtpad[k][(k-1)*W +: W]) << ((k-1)*W);
            w_sh[k]     = r_data[k-1] << w_chunk[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v   <= '0;
            r_sub <= '0;
            r_pos <= '0;
            r_sat <= '0;
            for (int unsigned k = 0; k <= STAGES; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
            end
        end else if (Flush) begin
            r_v <= '0;
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= InValid;
                if (InValid) begin
                    r_data[0] <= w_data;
                    r_amt[0]  <= w_amt;
                    r_sub[0]  <= w_ressub;
                    r_pos[0]  <= w_subpos;
                    r_sat[0]  <= w_sat;
                end
            end
            for (int unsigned k = 1; k <= STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_data[k] <= w_sh[k];
                        r_amt[k]  <= r_amt[k-1];
                        r_sub[k]  <= r_sub[k-1];
                        r_pos[k]  <= r_pos[k-1];
                        r_sat[k]  <= r_sat[k-1];
                    end
                end
            end
        end
    end

    assign OutValid        = r_v[STAGES];
    assign Shifted         = r_data[STAGES];
    assign ShiftAmt        = r_amt[STAGES];
    assign ResSubnorm      = r_sub[STAGES];
    assign SubnormShiftPos = r_pos[STAGES];
    assign ShiftSat        = r_sat[STAGES];

endmodule
